// File: rtl/uart_link_pkg.sv
// Shared types and helpers for the parametrised UART link.
package uart_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int unsigned MAX_DATA_W = 16;

    // Callers zero-extend their payload, so the XOR is unaffected by width.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] data);
        return ^data;
    endfunction

    function automatic int unsigned half_bit(input int unsigned oversample);
        return oversample / 2;
    endfunction

endpackage

// File: rtl/uart_link_checker_rx_core.sv
// Receiver: input register, mid-bit sampling FSM, payload and sticky error flags.
module uart_rx_core
    import uart_link_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              line,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int unsigned HALF  = half_bit(OVERSAMPLE);
    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    uart_state_e       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [BIT_W-1:0]  bit_idx, bit_idx_next;
    logic [DATA_W-1:0] rx_buf, rx_buf_next;
    logic [DATA_W-1:0] rx_data_next;
    logic              rx_sync;
    logic              par_bit, par_bit_next;
    logic              rx_valid_next, frame_err_next, parity_err_next;
    logic              bit_end;

    always_comb begin
        bit_end         = (cnt == CNT_W'(OVERSAMPLE - 1));
        state_next      = state;
        cnt_next        = bit_end ? '0 : cnt + 1'b1;
        bit_idx_next    = bit_idx;
        rx_buf_next     = rx_buf;
        par_bit_next    = par_bit;
        rx_valid_next   = 1'b0;
        rx_data_next    = rx_data;
        frame_err_next  = frame_err;
        parity_err_next = parity_err;

        case (state)
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (!rx_sync) state_next = START;
            end
            START: begin
                // A line that is high again at mid-start was only a glitch.
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_next   = '0;
                    state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    rx_buf_next = {rx_sync, rx_buf[DATA_W-1:1]};
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_bit_next = rx_sync;
                    state_next   = STOP;
                end
            end
            STOP: begin
                // Only the first stop bit is checked; RX is idle during any second one.
                if (bit_end) begin
                    state_next     = IDLE;
                    rx_valid_next  = 1'b1;
                    rx_data_next   = rx_buf;
                    frame_err_next = frame_err | ~rx_sync;
                    if (PARITY_EN != 0)
                        parity_err_next = parity_err |
                            (even_parity(MAX_DATA_W'(rx_buf)) ^ par_bit);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_buf     <= '0;
            rx_sync    <= 1'b1;
            par_bit    <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            rx_buf     <= rx_buf_next;
            rx_sync    <= line;
            par_bit    <= par_bit_next;
            rx_valid   <= rx_valid_next;
            rx_data    <= rx_data_next;
            frame_err  <= frame_err_next;
            parity_err <= parity_err_next;
        end
    end

endmodule

// File: rtl/uart_link_checker.sv
// UART link top: transmitter with load handshake, receiver core and sent/received checker.
module uart_link_checker
    import uart_link_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned LOOPBACK   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              ser_in,
    output logic              ser_out,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              frame_err,
    output logic              parity_err,
    output logic              ok
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    uart_state_e       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [BIT_W-1:0]  bit_idx, bit_idx_next;
    logic [DATA_W-1:0] tx_buf, tx_buf_next;
    logic [DATA_W-1:0] tx_shift, tx_shift_next;
    logic              bit_end, last_stop, accept;
    logic              rx_line;

    always_comb begin
        bit_end       = (cnt == CNT_W'(OVERSAMPLE - 1));
        last_stop     = (state == STOP) && bit_end && (bit_idx == BIT_W'(STOP_BITS - 1));
        // Ready in the final stop cycle too, so back-to-back frames have no gap.
        ld_ready      = (state == IDLE) || last_stop;
        accept        = ld_valid && ld_ready;
        state_next    = state;
        cnt_next      = bit_end ? '0 : cnt + 1'b1;
        bit_idx_next  = bit_idx;
        tx_buf_next   = tx_buf;
        tx_shift_next = tx_shift;
        ser_out       = 1'b1;

        case (state)
            IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
            end
            START: begin
                ser_out = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                ser_out = tx_shift[0];
                if (bit_end) begin
                    tx_shift_next = tx_shift >> 1;
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                ser_out = even_parity(MAX_DATA_W'(tx_buf));
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        state_next   = IDLE;
                        bit_idx_next = '0;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Accept realigns the bit timer to this edge.
        if (accept) begin
            state_next    = START;
            cnt_next      = '0;
            bit_idx_next  = '0;
            tx_buf_next   = ld_data;
            tx_shift_next = ld_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            tx_buf   <= '0;
            tx_shift <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_idx_next;
            tx_buf   <= tx_buf_next;
            tx_shift <= tx_shift_next;
        end
    end

    assign rx_line = (LOOPBACK != 0) ? ser_out : ser_in;

    uart_rx_core #(
        .DATA_W     (DATA_W),
        .OVERSAMPLE (OVERSAMPLE),
        .PARITY_EN  (PARITY_EN)
    ) rx_core (
        .clock      (clock),
        .reset      (reset),
        .line       (rx_line),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    // Compares against tx_buf as it stands this cycle; a simultaneous load lands next cycle.
    always_ff @(posedge clock) begin
        if (!reset)
            ok <= 1'b1;
        else if (rx_valid)
            ok <= (rx_data == tx_buf) && !frame_err && !parity_err;
    end

endmodule

// File: tb/tb_uart_link_checker.sv
// Randomised bench for uart_link_checker: a loopback instance with defaults and an external-line parity instance.
module tb_uart_link_checker;

    localparam int unsigned W0 = 8, OS0 = 16, P0 = 0, S0 = 1;
    localparam int unsigned W1 = 7, OS1 = 16, P1 = 1, S1 = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          rst0 = 1'b0, rst1 = 1'b0;
    logic          ldv0 = 1'b0, ldv1 = 1'b0;
    logic [W0-1:0] ldd0 = '0;
    logic [W1-1:0] ldd1 = '0;
    logic          rdy0, rdy1, so0, so1, rxv0, rxv1, fe0, fe1, pe0, pe1, ok0, ok1;
    logic [W0-1:0] rxd0;
    logic [W1-1:0] rxd1;
    logic          inject = 1'b1, bench_line = 1'b1;
    logic          si1;

    assign si1 = inject ? bench_line : so1;

    uart_link_checker dut0 (
        .clock(clock), .reset(rst0), .ld_valid(ldv0), .ld_data(ldd0), .ld_ready(rdy0),
        .ser_in(1'b1), .ser_out(so0), .rx_valid(rxv0), .rx_data(rxd0),
        .frame_err(fe0), .parity_err(pe0), .ok(ok0)
    );

    uart_link_checker #(
        .DATA_W(W1), .OVERSAMPLE(OS1), .PARITY_EN(P1), .STOP_BITS(S1), .LOOPBACK(0)
    ) dut1 (
        .clock(clock), .reset(rst1), .ld_valid(ldv1), .ld_data(ldd1), .ld_ready(rdy1),
        .ser_in(si1), .ser_out(so1), .rx_valid(rxv1), .rx_data(rxd1),
        .frame_err(fe1), .parity_err(pe1), .ok(ok1)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: frames as bit lists indexed by elapsed time, receiver as sample instants.
    int          pw[2]    = '{W0, W1};
    int          pos[2]   = '{OS0, OS1};
    int          ppar[2]  = '{P0, P1};
    int          pstop[2] = '{S0, S1};
    bit          armed[2];
    bit          tx_busy[2];
    int          tx_el[2];
    bit          tx_frame[2][32];
    logic [15:0] m_buf[2];
    bit          m_ser[2], m_rdy[2], m_rxv[2], m_fe[2], m_pe[2], m_ok[2];
    logic [15:0] m_rxd[2];
    bit          rx_busy[2];
    int          rx_t0[2];
    bit          hs[2][1024];

    task automatic model_edge(input int d, input bit rst_n, input bit ldv, input logic [15:0] ldd,
                              input bit use_ext, input bit ext_val, input int t);
        int w, os, half, flen, idx;
        bit s;
        logic [15:0] data;
        bit pbit;
        w = pw[d]; os = pos[d]; half = os / 2;
        flen = (1 + w + ppar[d] + pstop[d]) * os;
        if (!rst_n) begin
            armed[d] = 1; tx_busy[d] = 0; tx_el[d] = 0; m_buf[d] = '0;
            m_rxv[d] = 0; m_rxd[d] = '0; m_fe[d] = 0; m_pe[d] = 0; m_ok[d] = 1;
            rx_busy[d] = 0; hs[d][t % 1024] = 1;
        end else if (armed[d]) begin
            s = hs[d][(t - 1) % 1024];
            hs[d][t % 1024] = use_ext ? ext_val : m_ser[d];
            if (m_rxv[d]) m_ok[d] = (m_rxd[d] == m_buf[d]) && !m_fe[d] && !m_pe[d];
            m_rxv[d] = 0;
            if (!rx_busy[d]) begin
                if (!s) begin rx_busy[d] = 1; rx_t0[d] = t; end
            end else if (t - rx_t0[d] == half) begin
                if (s) rx_busy[d] = 0;
            end else if (t - rx_t0[d] == half + (1 + w + ppar[d]) * os) begin
                data = '0;
                for (int i = 0; i < w; i++)
                    data[i] = hs[d][(rx_t0[d] + half + (i + 1) * os - 1) % 1024];
                pbit = hs[d][(rx_t0[d] + half + (w + 1) * os - 1) % 1024];
                m_rxv[d] = 1; m_rxd[d] = data;
                if (!s) m_fe[d] = 1;
                if (ppar[d] != 0 && pbit != ^data) m_pe[d] = 1;
                rx_busy[d] = 0;
            end
            if (ldv && m_rdy[d]) begin
                tx_busy[d] = 1; tx_el[d] = 0; m_buf[d] = ldd;
                tx_frame[d][0] = 0;
                for (int i = 0; i < w; i++) tx_frame[d][1 + i] = ldd[i];
                idx = 1 + w;
                if (ppar[d] != 0) begin tx_frame[d][idx] = ^ldd; idx++; end
                for (int j = 0; j < pstop[d]; j++) tx_frame[d][idx + j] = 1;
            end else if (tx_busy[d]) begin
                tx_el[d]++;
                if (tx_el[d] == flen) tx_busy[d] = 0;
            end
        end
        m_ser[d] = tx_busy[d] ? tx_frame[d][tx_el[d] / os] : 1'b1;
        m_rdy[d] = !tx_busy[d] || tx_el[d] == flen - 1;
    endtask

    always @(posedge clock) begin
        cyc++;
        model_edge(0, rst0, ldv0, 16'(ldd0), 1'b0, 1'b0, cyc);
        model_edge(1, rst1, ldv1, 16'(ldd1), inject, bench_line, cyc);
    end

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (armed[d]) begin
                check(d == 0 ? "ser_out0" : "ser_out1",     32'(d == 0 ? so0 : so1),   32'(m_ser[d]));
                check(d == 0 ? "ld_ready0" : "ld_ready1",   32'(d == 0 ? rdy0 : rdy1), 32'(m_rdy[d]));
                check(d == 0 ? "rx_valid0" : "rx_valid1",   32'(d == 0 ? rxv0 : rxv1), 32'(m_rxv[d]));
                check(d == 0 ? "rx_data0" : "rx_data1",     d == 0 ? 32'(rxd0) : 32'(rxd1), 32'(m_rxd[d]));
                check(d == 0 ? "frame_err0" : "frame_err1", 32'(d == 0 ? fe0 : fe1),   32'(m_fe[d]));
                check(d == 0 ? "parity_err0" : "parity_err1", 32'(d == 0 ? pe0 : pe1), 32'(m_pe[d]));
                check(d == 0 ? "ok0" : "ok1",               32'(d == 0 ? ok0 : ok1),   32'(m_ok[d]));
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic run0();
        int k, pulses;
        bit exp_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        repeat (2) @(negedge clock);
        check("rst_ser_out", 32'(so0), 32'd1);
        check("rst_ld_ready", 32'(rdy0), 32'd1);
        check("rst_rx_valid", 32'(rxv0), 32'd0);
        check("rst_rx_data", 32'(rxd0), 32'd0);
        check("rst_flags", {30'd0, fe0, pe0}, 32'd0);
        check("rst_ok", 32'(ok0), 32'd1);
        rst0 = 1'b1;
        ldv0 = 1'b1; ldd0 = 8'hA5;
        @(negedge clock); k = cyc; ldv0 = 1'b0;
        for (int b = 0; b < 10; b++) begin
            wait_until(k + 16 * b + 8);
            check("a5_bit", 32'(so0), 32'(exp_seq[b]));
        end
        wait_until(k + 153); check("a5_rxv_early", 32'(rxv0), 32'd0);
        wait_until(k + 154); check("a5_rxv", 32'(rxv0), 32'd1); check("a5_rxd", 32'(rxd0), 32'hA5);
        wait_until(k + 155); check("a5_ok", 32'(ok0), 32'd1);

        wait_until(k + 170);
        ldv0 = 1'b1; ldd0 = 8'h00;
        @(negedge clock); k = cyc; ldd0 = 8'hFF;
        wait_until(k + 154); check("b2b_rxv1", 32'(rxv0), 32'd1); check("b2b_rxd1", 32'(rxd0), 32'h00);
        wait_until(k + 155); check("b2b_ok1", 32'(ok0), 32'd1);
        wait_until(k + 159); check("b2b_ready", 32'(rdy0), 32'd1);
        wait_until(k + 160); check("b2b_start", 32'(so0), 32'd0); check("b2b_busy", 32'(rdy0), 32'd0);
        ldv0 = 1'b0;
        wait_until(k + 314); check("b2b_rxv2", 32'(rxv0), 32'd1); check("b2b_rxd2", 32'(rxd0), 32'hFF);
        wait_until(k + 315); check("b2b_ok2", 32'(ok0), 32'd1);

        wait_until(k + 330);
        ldv0 = 1'b1; ldd0 = 8'h5A;
        @(negedge clock); k = cyc; ldv0 = 1'b0;
        wait_until(k + 40); rst0 = 1'b0;
        @(negedge clock);
        check("abort_ser_out", 32'(so0), 32'd1);
        check("abort_ready", 32'(rdy0), 32'd1);
        rst0 = 1'b1; pulses = 0;
        repeat (200) begin @(negedge clock); pulses += int'(rxv0); end
        check("abort_no_rxv", 32'(pulses), 32'd0);
        ldv0 = 1'b1; ldd0 = 8'h3C;
        @(negedge clock); k = cyc; ldv0 = 1'b0;
        wait_until(k + 154); check("3c_rxv", 32'(rxv0), 32'd1); check("3c_rxd", 32'(rxd0), 32'h3C);
        wait_until(k + 155); check("3c_ok", 32'(ok0), 32'd1);

        repeat (6000) begin
            @(negedge clock);
            ldv0 = ($urandom_range(0, 3) == 0);
            ldd0 = 8'($urandom);
            rst0 = ($urandom_range(0, 1999) != 0);
        end
        rst0 = 1'b1; ldv0 = 1'b0;
        repeat (400) @(negedge clock);
    endtask

    task automatic send_frame(input logic [W1-1:0] data, input bit bad_par, input bit bad_stop,
                              output int pulses);
        bit bits[11];
        pulses = 0;
        bits[0] = 0;
        for (int i = 0; i < 7; i++) bits[1 + i] = data[i];
        bits[8]  = (^data) ^ bad_par;
        bits[9]  = !bad_stop;
        bits[10] = 1;
        for (int b = 0; b < 11; b++) begin
            bench_line = bits[b];
            repeat (OS1) begin @(negedge clock); pulses += int'(rxv1); end
        end
        bench_line = 1'b1;
        repeat (30) begin @(negedge clock); pulses += int'(rxv1); end
    endtask

    task automatic run1();
        int pulses;
        repeat (2) @(negedge clock);
        check("rst1_ok", 32'(ok1), 32'd1);
        check("rst1_flags", {30'd0, fe1, pe1}, 32'd0);
        rst1 = 1'b1;

        bench_line = 1'b0;
        repeat (3) @(negedge clock);
        bench_line = 1'b1; pulses = 0;
        repeat (40) begin @(negedge clock); pulses += int'(rxv1); end
        check("glitch_no_rxv", 32'(pulses), 32'd0);
        check("glitch_flags", {30'd0, fe1, pe1}, 32'd0);

        send_frame(7'h55, 1'b1, 1'b0, pulses);
        check("par_pulses", 32'(pulses), 32'd1);
        check("par_rxd", 32'(rxd1), 32'h55);
        check("par_err", 32'(pe1), 32'd1);
        check("par_ferr", 32'(fe1), 32'd0);
        check("par_ok", 32'(ok1), 32'd0);
        repeat (100) @(negedge clock);
        check("par_sticky", 32'(pe1), 32'd1);
        rst1 = 1'b0; @(negedge clock);
        check("par_cleared", {30'd0, fe1, pe1}, 32'd0);
        rst1 = 1'b1;

        send_frame(7'h2A, 1'b0, 1'b1, pulses);
        check("ferr_pulses", 32'(pulses), 32'd1);
        check("ferr_set", 32'(fe1), 32'd1);
        check("ferr_perr", 32'(pe1), 32'd0);
        check("ferr_ok", 32'(ok1), 32'd0);
        rst1 = 1'b0; @(negedge clock); rst1 = 1'b1;

        inject = 1'b0;
        repeat (4000) begin
            @(negedge clock);
            ldv1 = ($urandom_range(0, 2) == 0);
            ldd1 = 7'($urandom);
            rst1 = ($urandom_range(0, 1499) != 0);
        end
        rst1 = 1'b1; ldv1 = 1'b0;
        repeat (200) @(negedge clock);
        inject = 1'b1;
        repeat (8) begin
            send_frame(7'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, pulses);
            repeat (20) @(negedge clock);
        end
    endtask

    initial begin
        fork
            run0();
            run1();
        join
        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by cycle %0d, required finish before time limit", cyc);
        $fatal(1, "time limit reached");
    end

endmodule
